// File: rtl/key_bit_entry.sv
// Purpose: turns two raw active-low buttons into serial bits plus a shift strobe, and counts pattern matches.
// Latency: a raw edge first captured at clock t+1 gives shift_en at clock t+3+DEB_CYCLES.
// Backpressure: none; the downstream display must accept every shift_en strobe.
//
// Ports:
//   clk1        system clock, rising edge
//   reset       asynchronous active-low reset
//   key0_n      raw button entering '0' (low = pressed, asynchronous)
//   key1_n      raw button entering '1' (low = pressed, asynchronous)
//   bit_out     last accepted bit, held until the next one
//   shift_en    one-cycle strobe per accepted bit
//   match       one-cycle pulse with shift_en when the newest PLEN bits equal PATTERN
//   match_count saturating number of matches since reset
module key_bit_entry #(
    parameter int                DEB_CYCLES = 16,
    parameter int                PLEN       = 4,
    parameter logic [PLEN-1:0]   PATTERN    = 4'b1011,
    parameter int                CNT_W      = 8
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             key0_n,
    input  logic             key1_n,
    output logic             bit_out,
    output logic             shift_en,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int FW = $clog2(PLEN + 1);

    // Index 0 is key0, index 1 is key1.
    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [1:0]          r_stable;
    logic [1:0]          r_stable_d;
    logic [DW-1:0]       r_deb_cnt [2];

    logic                r_bit;
    logic                r_shift;
    logic                r_match;
    logic [CNT_W-1:0]    r_count;
    logic [PLEN-1:0]     r_hist;
    logic [FW-1:0]       r_fill;

    logic [1:0]          w_raw;
    logic [1:0]          w_press;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_acc;
    logic [PLEN-1:0]     w_hist_nxt;
    logic [FW-1:0]       w_fill_nxt;
    logic                w_match_nxt;

    assign w_raw = {key1_n, key0_n};

    // Press events are seen the cycle after the stable state falls, so the
    // other key's stable state in that cycle already reflects any press of it
    // in the same cycle; simultaneous presses therefore reject each other.
    assign w_press = r_stable_d & ~r_stable;
    assign w_acc0  = w_press[0] & r_stable[1];
    assign w_acc1  = w_press[1] & r_stable[0];
    assign w_acc   = w_acc0 | w_acc1;

    assign w_hist_nxt  = {r_hist[PLEN-2:0], w_acc1};
    assign w_fill_nxt  = (r_fill == FW'(PLEN)) ? r_fill : r_fill + 1'b1;
    // Fill gating keeps the reset-zeroed history from matching a pattern
    // that starts with zeros before PLEN real bits have arrived.
    assign w_match_nxt = (w_fill_nxt == FW'(PLEN)) && (w_hist_nxt == PATTERN);

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_stable   <= 2'b11;
            r_stable_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_stable[i]  <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_bit   <= 1'b0;
            r_shift <= 1'b0;
            r_match <= 1'b0;
            r_count <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
        end else begin
            r_shift <= w_acc;
            r_match <= w_acc & w_match_nxt;
            if (w_acc) begin
                r_bit  <= w_acc1;
                r_hist <= w_hist_nxt;
                r_fill <= w_fill_nxt;
                if (w_match_nxt && (r_count != {CNT_W{1'b1}})) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bit_out     = r_bit;
    assign shift_en    = r_shift;
    assign match       = r_match;
    assign match_count = r_count;

endmodule

// File: doc/key_bit_entry.md
Name: key_bit_entry

Overview:
- Upstream feeder for the 18-bit LED shift display.
- Takes two raw active-low pushbuttons: KEY0 enters '0', KEY1 enters '1'.
- Synchronises and debounces both buttons, then emits one serial bit plus a one-cycle shift strobe per accepted press.
- Also runs an overlapping pattern detector on the accepted bit stream and counts matches.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronised samples required to accept a level change (minimum 2).
- PLEN, 4: pattern length in bits (2..8).
- PATTERN, 4'b1011: target sequence. MSB is the oldest bit, LSB is the newest.
- CNT_W, 8: width of the match counter.

Ports:
- clk1  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- key0_n  in  1  raw button; low means pressed; asynchronous to clk1.
- key1_n  in  1  raw button; low means pressed; asynchronous to clk1.
- bit_out  out  1  value of the last accepted bit; drives the display's serial input.
- shift_en  out  1  one-cycle strobe per accepted bit; drives the display's shift enable.
- match  out  1  one-cycle pulse, coincident with shift_en, when the newest PLEN bits equal PATTERN.
- match_count  out  CNT_W  saturating count of matches since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: bit_out=0, shift_en=0, match=0, match_count=0.
  - Internal state: synchroniser flops=1, stable key states=1 (released), debounce counters=0, history=0, fill counter=0.
  - Reset takes effect immediately. It may assert mid-debounce or mid-strobe; any in-progress pulse is truncated.
- Synchronisation: each key passes through a 2-flop synchroniser.
- Debounce, per key:
  - When the synchronised value equals the stable state, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1 while still mismatched, the stable state takes the synchronised value and the counter clears.
  - Any return to equality before that point clears the counter; the glitch is rejected.
- Press event: the stable state transitions 1->0. Release transitions generate no event.
- Acceptance rules:
  - A press event on one key is accepted only if the other key's stable state is 1 in that cycle.
  - Press events on both keys in the same cycle: both are rejected; no strobe.
  - Pressing one key while the other is held: rejected.
- Latency: a clean raw falling edge sampled at cycle t yields the stable change at t+2+DEB_CYCLES and shift_en=1 at t+3+DEB_CYCLES. Exactly one strobe is produced per press, however long the key is held.
- Outputs on acceptance, all registered and updated in the same clock:
  - shift_en=1 for exactly one cycle.
  - bit_out = entered value, held until the next accepted bit.
  - history = {history[PLEN-2:0], bit}.
  - fill counter increments, saturating at PLEN.
- Match condition, evaluated on the updated history and fill counter: fill counter == PLEN and history == PATTERN.
  - On a match: match=1 in the same cycle as shift_en; match_count increments in that same edge.
  - match_count saturates at 2^CNT_W-1.
  - Overlapping matches count. Example: 1011011 yields two matches.
- shift_en and match are never asserted in consecutive cycles, since the debounce minimum prevents it. match=1 implies shift_en=1.
- Simultaneous reset and press: reset wins.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with keys idle, then release -> all outputs 0. Both keys idle for 100 cycles -> no shift_en.
- Bounce rejection (DEB_CYCLES=16): drive key1_n low for 15 cycles, high for 5, repeat 4 times -> shift_en never asserts. Then hold key1_n low -> shift_en=1 exactly 19 cycles after the sampled edge, bit_out=1, single pulse despite a 200-cycle hold.
- Pattern detection: clean presses entering 1,0,1,1,0,1,1 -> seven shift_en pulses; bit_out follows 1,0,1,1,0,1,1; match on the 4th and 7th pulses only; final match_count=2.
- Fill requirement: after reset, press 0,1,1 -> no match. History register must not alias a pattern with trailing zeros from reset.
- Key conflicts:
  - Both raw keys fall in the same cycle and are held -> no shift_en, no count change.
  - key0 held, then key1 pressed -> no strobe.
  - Release both, then press key0 alone -> shift_en with bit_out=0.
- Reset mid-operation: assert reset 5 cycles into a key1 debounce after match_count=2 -> count=0 immediately. After release, with key1 still held low, the stable state goes 1->0 after debounce and one bit '1' is accepted. This is the defined behaviour.
- Saturation (CNT_W=2): enter 1011 repeated through 5 matches -> match_count stops at 3; match still pulses on each occurrence.
